// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_exc_unit
//  Purpose  : Coprocessor-0 exception/interrupt unit for a classic 5-stage
//             MIPS-style pipeline. Holds SR (12), Cause (13), EPC (14) and
//             PRId (15). It detects interrupts and exceptions at the commit
//             point, raises a combinational flush request and captures the
//             exception context on the following rising edge.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   rising-edge system clock
//    reset      in   1   asynchronous, active-low reset
//    A1         in   5   mfc0 read register number
//    A2         in   5   mtc0 write register number
//    DIn        in  32   mtc0 write data
//    EN         in   1   mtc0 write enable
//    PC         in  32   PC of the instruction at the commit point
//    BDIn       in   1   commit instruction sits in a branch delay slot
//    ExcCodeIn  in   5   exception code from the pipeline (0 = none)
//    HWInt      in   6   level-sensitive external interrupt lines
//    EXLClr     in   1   eret at the commit point
//    Req        out  1   flush/redirect request to all pipeline registers
//    EPCOut     out 32   eret return address (with mtc0 EPC bypass)
//    DOut       out 32   mfc0 read data
// ============================================================================
module cp0_exc_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        EN,
   input  logic [31:0] PC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPCOut,
   output logic [31:0] DOut
);

   // -------------------------------------------------------------------------
   // Register numbers and constants
   // -------------------------------------------------------------------------
   localparam logic [4:0]  REG_SR     = 5'd12;
   localparam logic [4:0]  REG_CAUSE  = 5'd13;
   localparam logic [4:0]  REG_EPC    = 5'd14;
   localparam logic [4:0]  REG_PRID   = 5'd15;
   localparam logic [31:0] PRID_VALUE = 32'h2022_0007;

   // -------------------------------------------------------------------------
   // Architectural state
   // -------------------------------------------------------------------------
   logic [5:0]  sr_im_q,     sr_im_d;
   logic        sr_exl_q,    sr_exl_d;
   logic        sr_ie_q,     sr_ie_d;
   logic        cause_bd_q,  cause_bd_d;
   logic [5:0]  cause_ip_q,  cause_ip_d;
   logic [4:0]  cause_exc_q, cause_exc_d;
   // EPC is word aligned, so only bits [31:2] are stored.
   logic [31:2] epc_q,       epc_d;

   // -------------------------------------------------------------------------
   // Request detection
   // -------------------------------------------------------------------------
   logic        int_req;
   logic        exc_req;
   logic        req_w;
   logic        wr_sr;
   logic        wr_epc;
   logic [31:2] epc_capture;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic [31:0] epc_word;

   // Low PC bits never reach EPC (aligned capture); kept only as a sink.
   logic        unused_pc_lsbs;
   assign unused_pc_lsbs = ^PC[1:0];

   assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
   assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;

   // Reset gating keeps the pipeline from flushing while the unit is held.
   assign req_w = reset & (int_req | exc_req);
   assign Req   = req_w;

   assign wr_sr  = EN & (A2 == REG_SR);
   assign wr_epc = EN & (A2 == REG_EPC);

   // Delay-slot instructions restart at the branch: PC - 4. Working on the
   // word address, this is a decrement of PC[31:2] and wraps modulo 2^32.
   assign epc_capture = BDIn ? (PC[31:2] - 30'd1) : PC[31:2];

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      sr_im_d     = sr_im_q;
      sr_exl_d    = sr_exl_q;
      sr_ie_d     = sr_ie_q;
      cause_bd_d  = cause_bd_q;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;

      // Pending interrupt lines are sampled every edge regardless of Req.
      cause_ip_d  = HWInt;

      if (req_w) begin
         // Exception/interrupt entry wins over eret and over any mtc0 in
         // the same cycle; the mtc0 instruction is being flushed anyway.
         sr_exl_d    = 1'b1;
         cause_bd_d  = BDIn;
         cause_exc_d = int_req ? 5'd0 : ExcCodeIn;
         epc_d       = epc_capture;
      end else begin
         if (wr_sr) begin
            sr_im_d  = DIn[15:10];
            sr_exl_d = DIn[1];
            sr_ie_d  = DIn[0];
         end
         if (wr_epc) begin
            epc_d = DIn[31:2];
         end
         // eret clears EXL even if a simultaneous mtc0 SR tried to set it.
         if (EXLClr) begin
            sr_exl_d = 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_im_q     <= 6'd0;
         sr_exl_q    <= 1'b0;
         sr_ie_q     <= 1'b0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= 6'd0;
         cause_exc_q <= 5'd0;
         epc_q       <= 30'd0;
      end else begin
         sr_im_q     <= sr_im_d;
         sr_exl_q    <= sr_exl_d;
         sr_ie_q     <= sr_ie_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= cause_ip_d;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

   // -------------------------------------------------------------------------
   // Read-side views
   // -------------------------------------------------------------------------
   assign sr_word    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
   assign cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
   assign epc_word   = {epc_q, 2'b00};

   always_comb begin
      DOut = 32'd0;
      case (A1)
         REG_SR:    DOut = sr_word;
         REG_CAUSE: DOut = cause_word;
         REG_EPC:   DOut = epc_word;
         REG_PRID:  DOut = PRID_VALUE;
         default:   DOut = 32'd0;
      endcase
   end

   // mtc0 EPC directly followed by eret: forward the value being written so
   // the redirect does not have to wait for the register to update.
   always_comb begin
      EPCOut = epc_word;
      if (!reset) begin
         EPCOut = 32'd0;
      end else if (wr_epc) begin
         EPCOut = {DIn[31:2], 2'b00};
      end
   end

endmodule
`default_nettype wire

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low (ports clk, reset; polarity and synchronicity fixed).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 A1  input  5  CP0 read register number (mfc0).
REQ-005 A2  input  5  CP0 write register number (mtc0).
REQ-006 DIn  input  32  mtc0 write data.
REQ-007 EN  input  1  mtc0 write enable.
REQ-008 PC  input  32  PC of the instruction at the commit point.
REQ-009 BDIn  input  1  commit instruction is in a branch delay slot.
REQ-010 ExcCodeIn  input  5  exception code carried from the pipeline; 0 = none.
REQ-011 HWInt  input  6  external interrupt lines, level-sensitive.
REQ-012 EXLClr  input  1  eret at commit point.
REQ-013 Req  output  1  flush/redirect request to all pipeline registers.
REQ-014 EPCOut  output  32  return address for eret.
REQ-015 DOut  output  32  mfc0 read data.

Function
REQ-016 SHALL implement SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
REQ-017 SHALL implement Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; read-only to mtc0.
REQ-018 SHALL implement EPC (14), 32 bits, bits [1:0] always 0; PRId (15) constant 32'h2022_0007.
REQ-019 IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL; ExcReq = (ExcCodeIn != 0) & !SR.EXL.
REQ-020 Req SHALL be combinational = IntReq | ExcReq, forced 0 while reset = 0.
REQ-021 On a rising edge with Req = 1: EXL <= 1; Cause.BD <= BDIn; Cause.ExcCode <= (IntReq ? 5'd0 : ExcCodeIn); EPC <= (BDIn ? PC - 4 : PC) with bits [1:0] cleared.
REQ-022 Interrupt SHALL take priority over a simultaneous exception (ExcCode 0 is recorded).
REQ-023 Cause.IP SHALL be loaded from HWInt every rising edge, independent of Req.
REQ-024 mtc0 (EN = 1) SHALL write SR/EPC at the rising edge only when Req = 0; writes to Cause, PRId, or unimplemented numbers are ignored.
REQ-025 EXL update priority per edge: Req (set) > EXLClr (clear) > mtc0 SR write.
REQ-026 DOut SHALL be combinational from A1; unimplemented numbers return 0; latency 0 cycles.
REQ-027 EPCOut SHALL equal DIn (low 2 bits cleared) when EN = 1 and A2 = 14, otherwise EPC (bypass for mtc0 immediately followed by eret).
REQ-028 While EXL = 1, no new Req SHALL be raised (no nested exceptions); pending HWInt is held by the source and is taken on the first cycle after EXL clears.
REQ-029 PC - 4 SHALL wrap modulo 2^32.

Reset
REQ-030 reset = 0 SHALL asynchronously clear SR, Cause, and EPC to 0; Req = 0, DOut = 0 for A1 outside 15, EPCOut = 0.
REQ-031 Deassertion of reset SHALL take effect at the next rising edge; reset asserted mid-exception SHALL clear EXL and discard the capture.

Verification
REQ-032 Reset, then ExcCodeIn = 5'd10, PC = 32'h3010, BDIn = 0 -> Req = 1 same cycle; next edge EXL = 1, Cause.ExcCode = 10, EPC = 32'h3010, Req = 0.
REQ-033 SR = 32'h0000_0401 via mtc0, HWInt = 6'b000001, ExcCodeIn = 5'd4, PC = 32'h3020, BDIn = 1 -> Req = 1; Cause.ExcCode = 0, BD = 1, EPC = 32'h301C.
REQ-034 EXL = 1, ExcCodeIn = 5'd12 -> Req = 0, registers unchanged; assert EXLClr -> EXL = 0 next edge, Req = 1 the following cycle.
REQ-035 mtc0 A2 = 14, DIn = 32'h0000_3047 with EXLClr = 1 same cycle -> EPCOut = 32'h0000_3044 combinationally; EPC = 32'h3044 after edge.
REQ-036 mtc0 to SR with Req = 1 same cycle -> write discarded, EXL = 1; mfc0 A1 = 15 -> DOut = 32'h2022_0007; A1 = 9 -> DOut = 0.
REQ-037 reset pulsed low between edges while EXL = 1 -> SR/Cause/EPC read 0 immediately, Req = 0.
